debounce_multi: RTL and testbench

Parametrised multi-channel push-button conditioner for the front-panel input path. Each of `N_CH` raw, asynchronous button lines is synchronised and debounced with a programmable stability window. Per channel the block produces a debounced level plus one-cycle press, release and optional auto-repeat pulses. It sits between the board pins and the control FSMs and replaces the single-channel, fixed-window debouncer.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_ch.sv | 138 +++++++++++++
 rtl/debounce_multi.sv | 40 ++++
 tb/tb_debounce_multi.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Provides the per-channel state enum and the counter width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } db_state_t;

    // Bits needed to hold counts 0 .. max-1.
    function automatic int cnt_w(input int max);
        return (max < 2) ? 1 : $clog2(max);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability FSM, hold/repeat timer.
// Ports: clk_i, rst_ni, in_i (raw) -> level_o, press_o, release_o, repeat_o.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 16,
    parameter bit REPEAT_EN   = 1'b1,
    parameter int HOLD_CYC    = 1000,
    parameter int REPEAT_CYC  = 200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int CW   = cnt_w(STABLE_CYC);
    localparam int HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int HW   = cnt_w(HMAX);

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          rpt_q, rpt_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            rep_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rpt_q   <= rpt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rpt_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end else if (REPEAT_EN) begin
                    // Constant-false when repeat is not built, so the
                    // hold timer and flag reduce to constant zero.
                    if (!rep_q && hold_q == HOLD_LAST) begin
                        rpt_d  = 1'b1;
                        rep_d  = 1'b1;
                        hold_d = '0;
                    end else if (rep_q && hold_q == RPT_LAST) begin
                        rpt_d  = 1'b1;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                // hold_q/rep_q untouched: a short release glitch only
                // pauses repeat timing instead of restarting it.
                if (s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                    rep_d   = 1'b0;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign level_o   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign repeat_o  = rpt_q;

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent push-button debouncers with press/release/repeat pulses.
// Ports: clk_i, rst_ni, in_i[N_CH] -> level_o, press_o, release_o, repeat_o.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 16,
    parameter bit REPEAT_EN   = 1'b1,
    parameter int HOLD_CYC    = 1000,
    parameter int REPEAT_CYC  = 200
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] in_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CYC  (STABLE_CYC),
            .REPEAT_EN   (REPEAT_EN),
            .HOLD_CYC    (HOLD_CYC),
            .REPEAT_CYC  (REPEAT_CYC)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .in_i      (in_i[g]),
            .level_o   (level_o[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g]),
            .repeat_o  (repeat_o[g])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (repeat and no-repeat builds).
// Reference model tracks run lengths of disagreeing samples and held age.
module tb_debounce_multi;

    localparam int N      = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HOLD   = 10;
    localparam int REP    = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_r = '0;

    logic [N-1:0] lvl, prs, rel, rpt;
    logic [N-1:0] lvl0, prs0, rel0, rpt0;

    int checks = 0;
    int errors = 0;
    int e = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH(N), .SYNC_STAGES(SYNC), .STABLE_CYC(STABLE),
        .REPEAT_EN(1'b1), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in_r),
        .level_o(lvl), .press_o(prs), .release_o(rel), .repeat_o(rpt)
    );

    debounce_multi #(
        .N_CH(N), .SYNC_STAGES(SYNC), .STABLE_CYC(STABLE),
        .REPEAT_EN(1'b0), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in_r),
        .level_o(lvl0), .press_o(prs0), .release_o(rel0), .repeat_o(rpt0)
    );

    // Reference model
    logic [SYNC-1:0] syn_m [N];
    bit              lvl_m [N];
    int              run_m [N];
    int              age_m [N];
    logic [N-1:0]    ep_m, er_m, et_m;

    always @(posedge clk or negedge rst_n) begin : mdl
        bit s, l, p, q, t;
        int r, a;
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                syn_m[c] <= '0;
                lvl_m[c] <= 1'b0;
                run_m[c] <= 0;
                age_m[c] <= 0;
            end
            ep_m <= '0;
            er_m <= '0;
            et_m <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                s = syn_m[c][SYNC-1];
                l = lvl_m[c];
                r = run_m[c];
                a = age_m[c];
                p = 1'b0;
                q = 1'b0;
                t = 1'b0;
                if (s != l) begin
                    r = r + 1;
                    if (r == STABLE) begin
                        l = !l;
                        r = 0;
                        if (l) begin
                            p = 1'b1;
                            a = 0;
                        end else begin
                            q = 1'b1;
                        end
                    end
                end else begin
                    // Held time advances only on samples that continue
                    // an unbroken high run.
                    if (l && r == 0) begin
                        a = a + 1;
                        if (a >= HOLD && (a - HOLD) % REP == 0) t = 1'b1;
                    end
                    r = 0;
                end
                syn_m[c] <= {syn_m[c][SYNC-2:0], in_r[c]};
                lvl_m[c] <= l;
                run_m[c] <= r;
                age_m[c] <= a;
                ep_m[c]  <= p;
                er_m[c]  <= q;
                et_m[c]  <= t;
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time,
                     act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_level",   lvl,  {lvl_m[1], lvl_m[0]});
        chk("m_press",   prs,  ep_m);
        chk("m_release", rel,  er_m);
        chk("m_repeat",  rpt,  et_m);
        chk("m0_level",  lvl0, {lvl_m[1], lvl_m[0]});
        chk("m0_press",  prs0, ep_m);
        chk("m0_release", rel0, er_m);
        chk("m0_repeat", rpt0, '0);
    end

    task automatic step();
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    // Next posedge becomes edge 0.
    task automatic mark();
        e = -1;
    endtask

    task automatic wait_to(input int k);
        while (e < k) step();
    endtask

    int n;

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_level", lvl, 2'b00);
        chk("rst_press", prs, 2'b00);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Clean press on channel 0
        in_r = 2'b01;
        mark();
        wait_to(4);
        chk("cp_press_e4", prs, 2'b00);
        chk("cp_level_e4", lvl, 2'b00);
        step();
        chk("cp_press_e5", prs, 2'b01);
        chk("cp_level_e5", lvl, 2'b01);
        step();
        chk("cp_press_e6", prs, 2'b00);

        // Auto-repeat
        wait_to(14);
        chk("rp_e14", rpt, 2'b00);
        step();
        chk("rp_e15", rpt, 2'b01);
        step();
        chk("rp_e16", rpt, 2'b00);
        wait_to(18);
        chk("rp_e18", rpt, 2'b01);
        wait_to(21);
        chk("rp_e21", rpt, 2'b01);
        chk("rp0_e21", rpt0, 2'b00);

        // Two-cycle glitch low while held
        step();
        in_r = 2'b00;
        step();
        step();
        in_r = 2'b01;
        repeat (10) begin
            step();
            chk("gl_release", rel, 2'b00);
            chk("gl_level", lvl, 2'b01);
        end

        // Release
        in_r = 2'b00;
        mark();
        wait_to(4);
        chk("rl_level_e4", lvl, 2'b01);
        chk("rl_rel_e4", rel, 2'b00);
        step();
        chk("rl_rel_e5", rel, 2'b01);
        chk("rl_level_e5", lvl, 2'b00);
        step();
        chk("rl_rel_e6", rel, 2'b00);
        repeat (4) step();

        // Bounce 1,1,1,0 then steady high
        n = 0;
        foreach (in_r[i]) in_r[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_r[0] = (i < 3);
            step();
            if (prs[0]) n++;
        end
        in_r[0] = 1'b1;
        repeat (15) begin
            step();
            if (prs[0]) n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL bounce_presses actual=%0d required=1", n);
        end
        in_r = 2'b00;
        repeat (10) step();

        // Simultaneous press, staggered release
        in_r = 2'b11;
        mark();
        wait_to(4);
        chk("sim_press_e4", prs, 2'b00);
        step();
        chk("sim_press_e5", prs, 2'b11);
        chk("sim_level_e5", lvl, 2'b11);
        repeat (3) step();
        in_r = 2'b10;
        mark();
        step();
        step();
        in_r = 2'b00;
        wait_to(5);
        chk("st_rel_e5", rel, 2'b01);
        chk("st_lvl_e5", lvl, 2'b10);
        step();
        chk("st_rel_e6", rel, 2'b00);
        step();
        chk("st_rel_e7", rel, 2'b10);
        chk("st_lvl_e7", lvl, 2'b00);
        repeat (5) step();

        // Reset while held
        in_r = 2'b11;
        mark();
        wait_to(8);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_level", lvl, 2'b00);
        chk("ar_press", prs, 2'b00);
        chk("ar_release", rel, 2'b00);
        chk("ar_repeat", rpt, 2'b00);
        @(negedge clk);
        step();
        step();
        chk("ar_rel_hold", rel, 2'b00);
        rst_n = 1'b1;
        mark();
        wait_to(4);
        chk("ar_press_e4", prs, 2'b00);
        step();
        chk("ar_press_e5", prs, 2'b11);
        chk("ar0_press_e5", prs0, 2'b11);

        // Long hold: repeat build pulses, no-repeat build stays quiet
        n = 0;
        while (e < 55) begin
            step();
            if (rpt[0]) n++;
            chk("nr_repeat", rpt0, 2'b00);
        end
        checks++;
        if (n != 14) begin
            errors++;
            $display("FAIL hold_repeats actual=%0d required=14", n);
        end
        in_r = 2'b00;
        mark();
        wait_to(5);
        chk("nr_rel_e5", rel0, 2'b11);
        chk("nr_lvl_e5", lvl0, 2'b00);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
